// File: rtl/head_flit_route_unit.sv
// head_flit_route_unit: registered head-flit decoder and route holder for one
// router input port. Head/single flits look up their destination in a
// runtime-writable routing table. The resulting output-port request is held
// for the whole wormhole packet. Flits pass through one valid/ready register.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_flit/in_valid/in_ready     upstream flit handshake
//   out_flit/out_valid/out_ready  downstream flit handshake (registered)
//   route_req/route_valid         output-port request for the current packet
//   cfg_we/cfg_addr/cfg_wdata     routing table write port
//   cfg_rdata                     combinational table readback
//   err_route                     one-cycle pulse: head with destination >= N
//   err_proto                     one-cycle pulse: flit type illegal in state
module head_flit_route_unit #(
  parameter int unsigned N             = 4,
  parameter int unsigned INDEX         = 1,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PhitPerFlit   = 2,
  parameter int unsigned REQUEST_WIDTH = 2,
  parameter int unsigned DEFAULT_ROUTE = 0,
  localparam int unsigned FLIT_W       = PhitPerFlit * DATA_WIDTH,
  localparam int unsigned DEST_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REQUEST_WIDTH-1:0] route_req,
  output logic                     route_valid,
  input  logic                     cfg_we,
  input  logic [DEST_W-1:0]        cfg_addr,
  input  logic [REQUEST_WIDTH-1:0] cfg_wdata,
  output logic [REQUEST_WIDTH-1:0] cfg_rdata,
  output logic                     err_route,
  output logic                     err_proto
);

  localparam logic [REQUEST_WIDTH-1:0] DEF_R = REQUEST_WIDTH'(DEFAULT_ROUTE);
  localparam logic [REQUEST_WIDTH-1:0] IDX_R = REQUEST_WIDTH'(INDEX);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_PKT
  } state_t;

  state_t                   r_state;
  logic [FLIT_W-1:0]        r_out_flit;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic [REQUEST_WIDTH-1:0] r_route_req;
  logic                     r_route_valid;
  logic                     r_err_route;
  logic                     r_err_proto;
  logic [REQUEST_WIDTH-1:0] r_table [N];

  logic                     w_accept;
  logic                     w_xfer;
  logic [1:0]               w_type;
  logic                     w_is_hs;
  logic [DEST_W-1:0]        w_dest;
  logic                     w_dest_ok;
  logic                     w_cfg_ok;
  logic [REQUEST_WIDTH-1:0] w_lookup;
  logic                     w_new_route;
  logic [FLIT_W-1:0]        w_as_body;

  // Handshake and flit decode
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready;
  assign w_type    = in_flit[FLIT_W-1:FLIT_W-2];
  assign w_is_hs   = (w_type == T_HEAD) || (w_type == T_SINGLE);
  assign w_dest    = in_flit[DEST_W-1:0];
  assign w_dest_ok = 32'(w_dest) < N;
  assign w_cfg_ok  = 32'(cfg_addr) < N;
  assign w_as_body = {T_BODY, in_flit[FLIT_W-3:0]};

  // Table read sees the pre-edge contents, so a same-cycle write is not seen
  assign w_lookup  = w_dest_ok ? r_table[w_dest] : DEF_R;

  // Out-of-range readback reports the node id
  assign cfg_rdata = w_cfg_ok ? r_table[cfg_addr] : IDX_R;

  // A new packet route is taken only for a head/single accepted in IDLE
  assign w_new_route = w_accept && (r_state == S_IDLE) && w_is_hs;

  assign out_flit    = r_out_flit;
  assign out_valid   = r_out_valid;
  assign route_req   = r_route_req;
  assign route_valid = r_route_valid;
  assign err_route   = r_err_route;
  assign err_proto   = r_err_proto;

  // Packet FSM, output register, route holder and routing table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_out_flit    <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_route_req   <= DEF_R;
      r_route_valid <= 1'b0;
      r_err_route   <= 1'b0;
      r_err_proto   <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        r_table[i] <= DEF_R;
      end
    end else begin
      r_err_route <= 1'b0;
      r_err_proto <= 1'b0;

      if (cfg_we && w_cfg_ok) begin
        r_table[cfg_addr] <= cfg_wdata;
      end

      if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      // Route stays valid across a tail/head boundary when the next head
      // is accepted in the same cycle the last flit leaves
      if (w_xfer && r_out_last && !w_new_route) begin
        r_route_valid <= 1'b0;
      end

      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (w_is_hs) begin
              r_out_flit    <= in_flit;
              r_out_valid   <= 1'b1;
              r_out_last    <= (w_type == T_SINGLE);
              r_route_req   <= w_lookup;
              r_route_valid <= 1'b1;
              r_err_route   <= !w_dest_ok;
              if (w_type == T_HEAD) begin
                r_state <= S_PKT;
              end
            end else begin
              // Body/tail without a packet: dropped
              r_out_valid <= 1'b0;
              r_err_proto <= 1'b1;
            end
          end
          S_PKT: begin
            // Stray head/single inside a packet is demoted to body
            r_out_flit  <= w_is_hs ? w_as_body : in_flit;
            r_out_valid <= 1'b1;
            r_out_last  <= (w_type == T_TAIL);
            r_err_proto <= w_is_hs;
            if (w_type == T_TAIL) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_head_flit_route_unit.sv
// Bench for head_flit_route_unit: directed scenarios plus randomized traffic
// compared cycle by cycle with a packet-level reference model and a flit
// stream scoreboard.
module tb_head_flit_route_unit;

  localparam int NN     = 6;
  localparam int INDEX  = 1;
  localparam int DEF    = 2;
  localparam int FW     = 16;
  localparam int DW     = 3;
  localparam int RW     = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] route_req;
  logic          route_valid;
  logic          cfg_we;
  logic [DW-1:0] cfg_addr;
  logic [RW-1:0] cfg_wdata;
  logic [RW-1:0] cfg_rdata;
  logic          err_route;
  logic          err_proto;

  head_flit_route_unit #(
    .N(NN), .INDEX(INDEX), .DATA_WIDTH(8), .PhitPerFlit(2),
    .REQUEST_WIDTH(RW), .DEFAULT_ROUTE(DEF)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .route_req(route_req), .route_valid(route_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .err_route(err_route), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: packet open flag, one-entry output stage,
  // held route, routing table, and the expected forwarded flit stream.
  logic          m_pkt;
  logic          m_ov;
  logic [FW-1:0] m_of;
  logic          m_last;
  logic          m_rv;
  logic [RW-1:0] m_rr;
  logic          m_er;
  logic          m_ep;
  logic [RW-1:0] m_tab [NN];
  logic [FW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int t, input int d, input int pl);
    mk = {2'(t), 11'(pl), 3'(d)};
  endfunction

  task automatic model_reset();
    m_pkt = 1'b0; m_ov = 1'b0; m_of = '0; m_last = 1'b0;
    m_rv = 1'b0; m_rr = RW'(DEF); m_er = 1'b0; m_ep = 1'b0;
    for (int i = 0; i < NN; i++) m_tab[i] = RW'(DEF);
    exp_q.delete();
  endtask

  task automatic model_step(input logic iv, input logic [FW-1:0] f, input logic ordy,
                            input logic we, input logic [DW-1:0] a, input logic [RW-1:0] wd);
    logic acc, xfer, hs, starts;
    logic [1:0] t;
    logic [FW-1:0] fwd;
    int d;
    acc    = iv && (!m_ov || ordy);
    xfer   = m_ov && ordy;
    t      = f[FW-1:FW-2];
    hs     = (t == 2'b01) || (t == 2'b11);
    d      = int'(f[DW-1:0]);
    starts = acc && !m_pkt && hs;
    m_er = 1'b0;
    m_ep = 1'b0;
    if (xfer) m_ov = 1'b0;
    if (xfer && m_last && !starts) m_rv = 1'b0;
    if (acc && !m_pkt) begin
      if (hs) begin
        m_ov = 1'b1; m_of = f; m_last = (t == 2'b11);
        m_rv = 1'b1;
        m_rr = (d < NN) ? m_tab[d] : RW'(DEF);
        m_er = (d >= NN);
        m_pkt = (t == 2'b01);
        exp_q.push_back(f);
      end else begin
        m_ep = 1'b1;
      end
    end else if (acc) begin
      fwd = hs ? {2'b00, f[FW-3:0]} : f;
      m_ov = 1'b1; m_of = fwd; m_last = (t == 2'b10);
      m_ep = hs;
      if (t == 2'b10) m_pkt = 1'b0;
      exp_q.push_back(fwd);
    end
    if (we && int'(a) < NN) m_tab[int'(a)] = wd;
  endtask

  task automatic check_regs();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) chk("out_flit", 32'(out_flit), 32'(m_of));
    chk("route_valid", 32'(route_valid), 32'(m_rv));
    if (m_rv) chk("route_req", 32'(route_req), 32'(m_rr));
    chk("err_route", 32'(err_route), 32'(m_er));
    chk("err_proto", 32'(err_proto), 32'(m_ep));
  endtask

  // One clock cycle: drive at negedge, check combinational outputs and the
  // departing flit, advance the model, check registered outputs after posedge.
  task automatic cyc(input logic iv, input logic [FW-1:0] f, input logic ordy,
                     input logic we, input logic [DW-1:0] a, input logic [RW-1:0] wd);
    logic [FW-1:0] e;
    @(negedge clk);
    in_valid = iv; in_flit = f; out_ready = ordy;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_ov || ordy));
    chk("cfg_rdata", 32'(cfg_rdata), (int'(a) < NN) ? 32'(m_tab[int'(a)]) : 32'(INDEX));
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(out_flit), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_flit", 32'(out_flit), 32'(e));
      end
    end
    model_step(iv, f, ordy, we, a, wd);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  int   rv_cnt;
  logic rv_low;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_flit", 32'(out_flit), 32'd0);
    chk("rst_route_valid", 32'(route_valid), 32'd0);
    chk("rst_route_req", 32'(route_req), 32'(DEF));
    chk("rst_errs", 32'({err_route, err_proto}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Program table {0:2,1:1,2:3,3:0}; read back every address
    cyc(1'b0, '0, 1'b1, 1'b1, 3'd0, 2'd2);
    cyc(1'b0, '0, 1'b1, 1'b1, 3'd1, 2'd1);
    cyc(1'b0, '0, 1'b1, 1'b1, 3'd2, 2'd3);
    cyc(1'b0, '0, 1'b1, 1'b1, 3'd3, 2'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, DW'(i), '0);

    // Head dest=2, body, tail back to back: route 3 for exactly 3 cycles
    rv_cnt = 0;
    cyc(1'b1, mk(1, 2, 11), 1'b1, 1'b0, '0, '0);
    chk("t1_route", 32'(route_req), 32'd3);
    if (route_valid) rv_cnt++;
    cyc(1'b1, mk(0, 5, 12), 1'b1, 1'b0, '0, '0);
    if (route_valid) rv_cnt++;
    cyc(1'b1, mk(2, 6, 13), 1'b1, 1'b0, '0, '0);
    if (route_valid) rv_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, '0, '0);
      if (route_valid) rv_cnt++;
    end
    chk("t1_rv_cycles", 32'(rv_cnt), 32'd3);

    // Downstream stall of 4 cycles mid-packet
    cyc(1'b1, mk(1, 0, 21), 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, mk(0, 1, 22), 1'b0, 1'b0, '0, '0);
      chk("t2_stall_ready", 32'(in_ready), 32'd0);
      chk("t2_stall_route", 32'(route_req), 32'd2);
    end
    cyc(1'b1, mk(0, 1, 22), 1'b1, 1'b0, '0, '0);
    cyc(1'b1, mk(2, 1, 23), 1'b1, 1'b0, '0, '0);
    idle(2);
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);

    // Tail of packet A then head of packet B: route 3 -> 1, never invalid
    rv_low = 1'b0;
    cyc(1'b1, mk(1, 2, 31), 1'b1, 1'b0, '0, '0);
    rv_low |= !route_valid;
    cyc(1'b1, mk(0, 0, 32), 1'b1, 1'b0, '0, '0);
    rv_low |= !route_valid;
    cyc(1'b1, mk(2, 0, 33), 1'b1, 1'b0, '0, '0);
    rv_low |= !route_valid;
    chk("t3_route_a", 32'(route_req), 32'd3);
    cyc(1'b1, mk(1, 1, 34), 1'b1, 1'b0, '0, '0);
    rv_low |= !route_valid;
    chk("t3_route_b", 32'(route_req), 32'd1);
    chk("t3_rv_never_low", 32'(rv_low), 32'd0);
    cyc(1'b1, mk(2, 0, 35), 1'b1, 1'b0, '0, '0);
    idle(2);

    // Out-of-range destination 7 and in-range 5 (default entry)
    cyc(1'b1, mk(1, 7, 41), 1'b1, 1'b0, '0, '0);
    chk("t4_err_route", 32'(err_route), 32'd1);
    chk("t4_def_route", 32'(route_req), 32'(DEF));
    cyc(1'b1, mk(2, 0, 42), 1'b1, 1'b0, '0, '0);
    chk("t4_err_pulse", 32'(err_route), 32'd0);
    cyc(1'b1, mk(3, 5, 43), 1'b1, 1'b0, '0, '0);
    chk("t4_in_range", 32'(err_route), 32'd0);
    cyc(1'b1, mk(3, 6, 44), 1'b1, 1'b0, '0, '0);
    chk("t4_single_oor", 32'(err_route), 32'd1);
    idle(2);

    // Same-cycle write and lookup of entry 2 uses the old value
    cyc(1'b1, mk(1, 2, 51), 1'b1, 1'b1, 3'd2, 2'd1);
    chk("t5_old_value", 32'(route_req), 32'd3);
    cyc(1'b1, mk(2, 2, 52), 1'b1, 1'b0, '0, '0);
    chk("t5_held", 32'(route_req), 32'd3);
    cyc(1'b1, mk(1, 2, 53), 1'b1, 1'b0, '0, '0);
    chk("t5_new_value", 32'(route_req), 32'd1);
    cyc(1'b1, mk(2, 2, 54), 1'b1, 1'b0, '0, '0);
    idle(2);

    // Body in IDLE is dropped with a single err_proto pulse
    cyc(1'b1, mk(0, 1, 61), 1'b1, 1'b0, '0, '0);
    chk("t6_err_proto", 32'(err_proto), 32'd1);
    chk("t6_dropped", 32'(out_valid), 32'd0);
    idle(1);
    chk("t6_pulse_end", 32'(err_proto), 32'd0);

    // Randomized traffic with occasional table writes
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          int'($urandom)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
          DW'($urandom_range(0, 7)), RW'($urandom));
    end
    idle(3);
    chk("rand_sb_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a stalled packet
    cyc(1'b1, mk(1, 3, 71), 1'b1, 1'b1, 3'd4, 2'd3);
    cyc(1'b1, mk(0, 3, 72), 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_flit", 32'(out_flit), 32'd0);
    chk("arst_route_valid", 32'(route_valid), 32'd0);
    chk("arst_route_req", 32'(route_req), 32'(DEF));
    chk("arst_errs", 32'({err_route, err_proto}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NN; i++) cyc(1'b0, '0, 1'b1, 1'b0, DW'(i), '0);
    cyc(1'b1, mk(0, 0, 73), 1'b1, 1'b0, '0, '0);
    chk("arst_pkt_gone", 32'(err_proto), 32'd1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/head_flit_route_unit.md
Name: head_flit_route_unit

Overview:
- Parametrised, registered successor to the combinational head-flit decoder. Sits between an input buffer and the switch allocator of router node INDEX.
- Decodes the destination from each head flit and looks it up in a runtime-writable routing table. The resulting output-port request is held for the whole wormhole packet until the tail flit leaves.
- Flits pass through a single valid/ready pipeline register.

Parameters:
- N, 4, number of nodes; routing table depth.
- INDEX, 1, this node's id; reported on cfg readback only.
- DATA_WIDTH, 8, phit width in bits.
- PhitPerFlit, 2, phits per flit; FLIT_W = PhitPerFlit*DATA_WIDTH.
- REQUEST_WIDTH, 2, encoded output-port request width.
- DEFAULT_ROUTE, 0, request issued for out-of-range destinations; also the table reset value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_flit  input  FLIT_W  flit. Bits [FLIT_W-1:FLIT_W-2] are the type: 01 head, 00 body, 10 tail, 11 single. Head/single carry the destination in [DEST_W-1:0], DEST_W = max(1,$clog2(N)).
- in_valid  input  1  in_flit valid.
- in_ready  output  1  unit accepts in_flit this cycle.
- out_flit  output  FLIT_W  registered flit.
- out_valid  output  1  out_flit valid.
- out_ready  input  1  downstream accepts out_flit.
- route_req  output  REQUEST_WIDTH  output-port request for the current packet.
- route_valid  output  1  route_req meaningful; high from head acceptance through tail departure.
- cfg_we  input  1  routing table write strobe.
- cfg_addr  input  DEST_W  table entry index.
- cfg_wdata  input  REQUEST_WIDTH  entry value.
- cfg_rdata  output  REQUEST_WIDTH  combinational read of entry cfg_addr.
- err_route  output  1  one-cycle pulse: accepted head with destination >= N.
- err_proto  output  1  one-cycle pulse: accepted flit whose type is illegal for the current state.

Behaviour:
- Reset (async, any time, including mid-packet):
  - out_valid=0, out_flit=0, route_req=DEFAULT_ROUTE, route_valid=0, err_*=0.
  - State=IDLE; every table entry = DEFAULT_ROUTE.
  - Any in-flight packet is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready; transfer out = out_valid && out_ready.
  - Accepted flit appears on out_flit the next cycle (latency 1). Full throughput: one flit per cycle under continuous out_ready.
  - out_flit and route_req hold stable while out_valid && !out_ready.
- FSM states: IDLE, PKT.
  - IDLE, accept head: register lookup result into route_req; route_valid=1 with out_valid; -> PKT.
  - IDLE, accept single: same lookup; -> stays IDLE; route_valid drops after that flit transfers out unless a new head was accepted in the same cycle.
  - IDLE, accept body/tail: flit dropped (not forwarded), err_proto pulse, stay IDLE.
  - PKT, accept body: forwarded, route_req unchanged.
  - PKT, accept tail: forwarded, -> IDLE. route_valid clears on the cycle after the tail transfers out, unless a head/single was accepted in that transfer cycle; then route_req updates to the new lookup with route_valid continuously high.
  - PKT, accept head/single: forwarded as body with route unchanged, err_proto pulse, stay PKT.
- Lookup:
  - Destination d = in_flit[DEST_W-1:0].
  - If d < N: route_req <= table[d]. Else route_req <= DEFAULT_ROUTE and err_route pulses.
- Config:
  - cfg_we writes table[cfg_addr] at the clock edge; writes with cfg_addr >= N are ignored.
  - A write and a lookup of the same entry in the same cycle: the lookup uses the OLD value. The new value is visible from the next cycle.
  - Table writes never alter route_req of a packet already in progress.
- Error pulses are registered and high for exactly one cycle per offending accept.

Test Plan:
- Program table {0:2,1:1,2:3,3:0}, stall out_ready=1. Head dest=2, body, tail on consecutive cycles -> out_flit stream 1 cycle later, route_req=3, route_valid high for exactly 3 cycles.
- out_ready=0 for 4 cycles mid-packet -> in_ready=0, out_flit and route_req stable. Release -> no flit lost or duplicated.
- Tail of packet A (route 3) and head dest=1 in back-to-back cycles -> route_req switches 3->1 with route_valid never low.
- Head dest=5 with N=6, then N=4 configuration with dest=7 via DEST_W=2 masking vs N=6 -> err_route pulse for out-of-range case, route_req=DEFAULT_ROUTE.
- cfg_we to entry 2 (value 1) in the same cycle as head dest=2 -> route_req=old value 3. Next head dest=2 -> 1.
- Body flit in IDLE -> dropped, err_proto=1 one cycle. Assert rst mid-packet -> all outputs reset immediately (async), table=DEFAULT_ROUTE.
